// File: rtl/iob_merge_rr_pkg.sv
// Shared types and field layout for the IOb round-robin merger.
// Request slot MSB..LSB: {valid, address, wdata, wstrb}; response slot: {rdata, ready}.
package iob_merge_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int RESP_READY_BIT = 0;
    localparam int RESP_RDATA_LSB = 1;

    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int resp_w(input int dw);
        return dw + 1;
    endfunction

    // Index width kept at least one bit so a single-master build still has a grant register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int valid_bit(input int aw, input int dw);
        return dw / 8 + dw + aw;
    endfunction

endpackage

// File: rtl/iob_merge_rr_if.sv
// Bundle of the merger's master-side and slave-side buses.
// Modport slave is the merger's own view; modport master is the surrounding environment.
interface iob_merge_rr_if
    import iob_merge_rr_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int RESP_W = resp_w(DATA_W);

    logic [N_MASTERS*REQ_W-1:0]  m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]            s_req;
    logic [RESP_W-1:0]           s_resp;

    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req
    );

    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req
    );
endinterface

// File: rtl/iob_merge_rr_pick.sv
// Rotating-priority encoder: first requester after index last_i, wrapping around.
// Lowest index above last_i wins; otherwise the lowest index overall (wrap, including last_i).
module iob_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] pick_o,
    output logic          any_o
);
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick_o = IW'(i);
                any_o  = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i] && (IW'(i) > last_i)) pick_o = IW'(i);
        end
    end
endmodule

// File: rtl/iob_merge_rr.sv
// Round-robin N-master to 1-slave IOb merger; one transaction in flight, grant held until ready.
// Ready returns combinationally from the slave; one idle cycle separates transactions.
module iob_merge_rr
    import iob_merge_rr_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    iob_merge_rr_if.slave bus
);
    localparam int REQ_W     = req_w(ADDR_W, DATA_W);
    localparam int RESP_W    = resp_w(DATA_W);
    localparam int IW        = idx_w(N_MASTERS);
    localparam int VALID_BIT = valid_bit(ADDR_W, DATA_W);

    state_t                 state_q;
    logic [IW-1:0]          grant_q;
    logic [IW-1:0]          last_q;
    logic [IW-1:0]          pick;
    logic                   any;
    logic [N_MASTERS-1:0]   valid;
    logic                   busy;
    logic                   s_ready;
    logic [DATA_W-1:0]      s_rdata;
    logic [DATA_W-1:0]      rdata_b;

    assign busy    = (state_q == BUSY);
    assign s_ready = bus.s_resp[RESP_READY_BIT];
    assign s_rdata = bus.s_resp[RESP_RDATA_LSB +: DATA_W];
    assign rdata_b = busy ? s_rdata : '0;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slot
        assign valid[gi] = bus.m_req[gi*REQ_W + VALID_BIT];
        // Only the granted slot sees ready; rdata is shared by all slots.
        assign bus.m_resp[gi*RESP_W +: RESP_W] = {rdata_b, busy && (grant_q == IW'(gi)) && s_ready};
    end

    assign bus.s_req = busy ? bus.m_req[int'(grant_q)*REQ_W +: REQ_W] : '0;

    iob_rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req_i  (valid),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (any)
    );

    // last_q only advances on a completed transfer, so an aborting master keeps its turn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_MASTERS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (any) begin
                        grant_q <= pick;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end else if (!valid[grant_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/iob_merge_rr.md
Name: iob_merge_rr

Overview:
- Round-robin N-master to 1-slave merger for the IOb native bus.
- Lets a second bus master (crypto accelerator / DMA engine) share the internal data path with the CPU data bus.
- Sits directly upstream of the data-bus split: its slave port drives the split's master port.
- Holds each grant until the slave returns ready; fair rotation, one transaction in flight.

Parameters:
- N_MASTERS, 2, number of master ports (2..8).
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low (asserted when 0); asserts asynchronously, releases on clk edge.
- m_req  input  N_MASTERS*REQ_W  master requests; slot i at [i*REQ_W +: REQ_W]; per-slot field order MSB..LSB {valid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}; REQ_W=1+ADDR_W+DATA_W+DATA_W/8.
- m_resp  output  N_MASTERS*RESP_W  master responses; slot i at [i*RESP_W +: RESP_W]; fields {rdata[DATA_W], ready}; RESP_W=DATA_W+1.
- s_req  output  REQ_W  merged request to the downstream split.
- s_resp  input  RESP_W  response from the downstream split.

Behaviour:
- Bus rule: a master holds valid and its fields stable until it sees ready=1. Writes have wstrb!=0; reads have wstrb=0. The slave pulses ready for one cycle per transaction, for both reads and writes.
- Registers: state {IDLE, BUSY}; grant[clog2(N)]; last[clog2(N)].
- Reset (rst=0): state=IDLE, grant=0, last=N_MASTERS-1 (master 0 has first priority). All s_req bits 0. Every m_resp ready=0; rdata=0.
- IDLE:
  - s_req.valid=0.
  - If any master valid: pick the first valid index scanning last+1, last+2, ... wrapping modulo N. Then grant<=pick, state<=BUSY.
- BUSY:
  - s_req = m_req slot[grant] unchanged (valid passes through).
  - m_resp[grant].ready = s_resp.ready; all other ready=0.
  - rdata = s_resp.rdata broadcast to all slots (qualified only by ready).
- BUSY exit:
  - s_resp.ready=1: last<=grant, state<=IDLE.
  - m_req[grant].valid=0 without ready (protocol violation/abort): state<=IDLE, last unchanged, no response delivered.
- Latency: request seen in IDLE at cycle t → s_req.valid at t+1. Slave ready at cycle u → master ready in the same cycle u (combinational path). Next arbitration decision at u+1; the following s_req.valid at u+2 (one-cycle bubble between transactions).
- Simultaneous requests: only the round-robin winner proceeds; losers keep valid asserted and wait. Their ready stays 0.
- New requests arriving during BUSY are ignored until IDLE.
- s_resp.ready in IDLE is ignored; it causes no m_resp ready.
- Reset mid-transaction: outputs drop asynchronously to reset values; the pending transaction is discarded.
- N_MASTERS=1 is legal: degenerates to a pass-through with one bubble cycle.

Decomposition:
- Shared header (existing interconnect include): REQ_W/RESP_W, field offset macros (valid, address, wdata, wstrb, rdata, ready), IDLE/BUSY state encodings.
- One sub-module, iob_rr_pick: combinational rotating-priority encoder.
  - Inputs: req[N], last[clog2 N].
  - Outputs: pick index, any.

Test Plan:
- Single master: m0 read addr 0x100 at t0; slave ready with rdata 0xDEADBEEF at t0+3 → s_req.valid at t0+1; m0 ready=1 with 0xDEADBEEF at t0+3; m1 ready stays 0.
- Contention after reset: m0 and m1 both valid at t0 → m0 granted first. After m0's ready, m1 gets s_req.valid two cycles later with its address/wdata intact.
- Fairness: m0 and m1 continuously requesting writes (wstrb=0xF) for 6 transactions → grant order 0,1,0,1,0,1; each write's wdata appears on s_req unchanged.
- Abort: m1 granted, drops valid before ready → FSM returns to IDLE the next cycle. No m1 ready; last unchanged, so m1 keeps priority next round.
- Reset mid-transaction: rst=0 while BUSY → s_req.valid=0 and all ready=0 immediately (asynchronously). After release, m0 has priority.
- Stray ready: s_resp.ready=1 while IDLE → all m_resp ready remain 0; state unchanged.
